// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Two-requester round-robin arbiter and sequencer for a 2048x16 SRAM.
//   Each transaction is serialised into the SRAM pin phases that the MAR/MDR
//   timing needs:
//     read  : IDLE -> RD_ADDR -> RD_DATA -> IDLE (done pulses in that IDLE)
//     write : IDLE -> WR_ADDR -> WR_STRB -> IDLE (done pulses in that IDLE)
//   Every output is a flop, so each output value is computed from the next
//   state and shows up during the state it belongs to.
//
// Ports
//   clk, rst            clock (posedge), synchronous active-high reset
//   req0/req1           request, held high until the matching done pulse
//   we0/we1             1 = write, 0 = read (stable while req is high)
//   addr0/addr1         word address        (stable while req is high)
//   wdata0/wdata1       write data          (stable while req is high)
//   done0/done1         one-cycle completion pulse
//   rdata               last read result, held until the next read completes
//   busy                high whenever the FSM is not in IDLE
//   sram_adrx           SRAM address
//   sram_nOE            SRAM output enable, active-low
//   sram_read           SRAM read / write-strobe line (write commits on rise)
//   sram_data           shared bus, driven {0,wdata} only in write states
//   dbg_state           current FSM state, for checkers
//
// Handshake: a requester raises req with we/addr/wdata stable and keeps them
// stable until it sees its done pulse. A requester is eligible only while
// req=1 and its done=0, so a request still high during its own done cycle is
// not granted a second time for the same transaction.
module sram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int BUS_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_adrx,
  output logic              sram_nOE,
  output logic              sram_read,
  inout  wire  [BUS_W-1:0]  sram_data,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_STRB = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0]   adrx_q, adrx_d;
  logic                read_q, read_d;
  logic                noe_q, noe_d;
  logic                drive_q, drive_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;

  logic                elig0, elig1, gnt1, sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Upper bus lines are never read back; they only carry zeros on writes.
  logic                unused_bus_hi;
  assign unused_bus_hi = ^sram_data[BUS_W-1:DATA_W];

  assign elig0 = req0 & ~done0_q;
  assign elig1 = req1 & ~done1_q;
  // With both eligible the one not granted last wins; last_gnt resets to 1,
  // so requester 0 goes first after reset.
  assign gnt1      = elig1 & (~elig0 | ~last_gnt_q);
  assign sel_we    = gnt1 ? we1    : we0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    adrx_d     = adrx_q;
    read_d     = 1'b1;
    noe_d      = 1'b1;
    drive_d    = 1'b0;
    wdata_d    = wdata_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    rdata_d    = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          last_gnt_d = gnt1;
          adrx_d     = sel_addr;
          wdata_d    = sel_wdata;
          if (sel_we) begin
            state_d = WR_ADDR;
            read_d  = 1'b0;
            drive_d = 1'b1;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        state_d = RD_DATA;
        noe_d   = 1'b0;
      end
      RD_DATA: begin
        // The SRAM drives MDR onto the bus during this state.
        rdata_d = sram_data[DATA_W-1:0];
        state_d = IDLE;
        done0_d = ~last_gnt_q;
        done1_d = last_gnt_q;
      end
      WR_ADDR: begin
        // sram_read rises entering WR_STRB with adrx unchanged: the commit.
        state_d = WR_STRB;
        drive_d = 1'b1;
      end
      WR_STRB: begin
        state_d = IDLE;
        done0_d = ~last_gnt_q;
        done1_d = last_gnt_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      adrx_q     <= '0;
      read_q     <= 1'b1;
      noe_q      <= 1'b1;
      drive_q    <= 1'b0;
      wdata_q    <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      adrx_q     <= adrx_d;
      read_q     <= read_d;
      noe_q      <= noe_d;
      drive_q    <= drive_d;
      wdata_q    <= wdata_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign sram_data = drive_q ? {{(BUS_W-DATA_W){1'b0}}, wdata_q} : {BUS_W{1'bz}};
  assign sram_adrx = adrx_q;
  assign sram_nOE  = noe_q;
  assign sram_read = read_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: behavioural SRAM on the pins, reference memory
// for expected read data, and a scoreboard queue of expected completions.
module tb_sram_arbiter;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_STRB = 3'd4;

  logic        clk, rst;
  logic        req0, req1, we0, we1;
  logic [10:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        done0, done1, busy, sram_nOE, sram_read;
  logic [15:0] rdata;
  logic [10:0] sram_adrx;
  logic [2:0]  dbg_state;
  wire  [31:0] sram_data;

  int checks = 0;
  int errors = 0;
  int done0_cnt = 0;
  int done1_cnt = 0;
  bit no_fall_win = 0;

  // {id, is_read, data}
  logic [17:0] exp_q[$];
  logic [15:0] ref_mem [0:2047];

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
    .sram_adrx(sram_adrx), .sram_nOE(sram_nOE), .sram_read(sram_read),
    .sram_data(sram_data), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- SRAM model ----------------
  logic [15:0] mem [0:2047];
  logic [10:0] mar = '0;
  logic [15:0] mdr = '0;
  logic        read_last = 1'b1;

  assign sram_data = (!sram_nOE) ? {16'h0000, mem[sram_adrx]} : {32{1'bz}};

  always @(negedge clk) begin
    if (!rst) begin
      if (!sram_read) begin
        mar <= sram_adrx;
        mdr <= sram_data[15:0];
        chk("bus_upper_zero", {16'h0, sram_data[31:16]}, 32'h0);
      end
      if (sram_read && !read_last) mem[mar] <= mdr;
    end
    read_last <= sram_read;
  end

  // ---------------- monitor / scoreboard ----------------
  logic read_mon = 1'b1;
  always @(negedge clk) begin
    if (!rst) begin
      chk("noe_only_rd_data", {31'h0, sram_nOE}, {31'h0, dbg_state != S_RD_DATA});
      chk("busy_vs_state", {31'h0, busy}, {31'h0, dbg_state != S_IDLE});
      if (sram_read && !read_mon)
        chk("read_rise_in_wr_strb", {29'h0, dbg_state}, {29'h0, S_WR_STRB});
      if (no_fall_win)
        chk("read_never_falls", {31'h0, sram_read}, 32'h1);
      if (done0 || done1) begin
        if (done0) done0_cnt++;
        if (done1) done1_cnt++;
        chk("done_exclusive", {31'h0, done0 & done1}, 32'h0);
        if (exp_q.size() == 0) begin
          chk("done_unexpected", {30'h0, done1, done0}, 32'h0);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("done_id", {31'h0, done1}, {31'h0, e[17]});
          if (e[16]) chk("rdata", {16'h0, rdata}, {16'h0, e[15:0]});
        end
      end
    end
    read_mon <= sram_read;
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_exp(input bit id, input bit we, input logic [10:0] a, input logic [15:0] d);
    if (we) begin
      ref_mem[a] = d;
      exp_q.push_back({id, 1'b0, 16'h0});
    end else begin
      exp_q.push_back({id, 1'b1, ref_mem[a]});
    end
  endtask

  task automatic set_req(input bit id, input bit we, input logic [10:0] a, input logic [15:0] d);
    if (id) begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
    else    begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
  endtask

  // Waits for done of requester id; returns the cycles waited.
  task automatic wait_done(input bit id, output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < 20) begin
      @(negedge clk);
      cycles++;
      got = id ? done1 : done0;
    end
    chk("done_seen", {31'h0, got}, 32'h1);
  endtask

  task automatic do_txn(input bit id, input bit we, input logic [10:0] a,
                        input logic [15:0] d, input int exp_lat);
    int cyc;
    @(negedge clk);
    set_req(id, we, a, d);
    push_exp(id, we, a, d);
    wait_done(id, cyc);
    if (exp_lat != 0) chk("latency", cyc, exp_lat);
    if (id) req1 = 1'b0; else req0 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, c0, c1, n;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // 1. reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_adrx", {21'h0, sram_adrx}, 32'h0);
    chk("rst_read", {31'h0, sram_read}, 32'h1);
    chk("rst_noe", {31'h0, sram_nOE}, 32'h1);
    chk("rst_done", {30'h0, done1, done0}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rdata", {16'h0, rdata}, 32'h0);
    chk("rst_state", {29'h0, dbg_state}, {29'h0, S_IDLE});
    rst = 1'b0;

    // 2. write then read back
    do_txn(0, 1, 11'h123, 16'hBEEF, 3);
    do_txn(0, 0, 11'h123, 16'h0000, 3);
    chk("mem_beef", {16'h0, mem[11'h123]}, 32'h0000BEEF);

    // 3. both requesters, same cycle after reset, alternate while held
    do_txn(0, 1, 11'h010, 16'h1111, 3);
    do_txn(1, 1, 11'h020, 16'h2222, 3);
    apply_reset(2);
    @(negedge clk);
    set_req(0, 0, 11'h010, 16'h0);
    set_req(1, 0, 11'h020, 16'h0);
    push_exp(0, 0, 11'h010, 16'h0);
    push_exp(1, 0, 11'h020, 16'h0);
    push_exp(0, 0, 11'h010, 16'h0);
    push_exp(1, 0, 11'h020, 16'h0);
    c0 = 0; c1 = 0; n = 0;
    while ((c0 < 2 || c1 < 2) && n < 60) begin
      @(negedge clk);
      n++;
      if (done0) begin c0++; if (c0 == 2) req0 = 1'b0; end
      if (done1) begin c1++; if (c1 == 2) req1 = 1'b0; end
    end
    chk("rr_done0_cnt", c0, 2);
    chk("rr_done1_cnt", c1, 2);
    chk("rr_cycles", n, 12);

    // 4. req0 held across back-to-back writes
    c0 = done0_cnt;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 11'(i), 16'(i + 1));
      push_exp(0, 1, 11'(i), 16'(i + 1));
      wait_done(0, cyc);
    end
    req0 = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_done_pulses", done0_cnt - c0, 4);
    for (int i = 0; i < 4; i++) do_txn(0, 0, 11'(i), 16'h0, 3);

    // 5. preload, idle, repeated reads
    do_txn(1, 1, 11'd5, 16'hA5A5, 3);
    repeat (50) @(negedge clk);
    chk("idle_adrx_held", {21'h0, sram_adrx}, 32'd5);
    no_fall_win = 1'b1;
    for (int i = 0; i < 10; i++) do_txn(i[0], 0, 11'd5, 16'h0, 3);
    no_fall_win = 1'b0;
    chk("mem5_unchanged", {16'h0, mem[5]}, 32'h0000A5A5);

    // 6. reset during RD_DATA
    @(negedge clk);
    set_req(0, 0, 11'h123, 16'h0);
    push_exp(0, 0, 11'h123, 16'h0);
    n = 0;
    while (dbg_state != S_RD_DATA && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reached_rd_data", {29'h0, dbg_state}, {29'h0, S_RD_DATA});
    rst = 1'b1;
    req0 = 1'b0;
    void'(exp_q.pop_back());
    c0 = done0_cnt;
    @(negedge clk);
    chk("rst6_state", {29'h0, dbg_state}, {29'h0, S_IDLE});
    chk("rst6_done", {30'h0, done1, done0}, 32'h0);
    chk("rst6_rdata", {16'h0, rdata}, 32'h0);
    chk("rst6_noe", {31'h0, sram_nOE}, 32'h1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst6_no_done", done0_cnt - c0, 0);
    chk("rst6_mem", {16'h0, mem[11'h123]}, 32'h0000BEEF);
    do_txn(0, 0, 11'h123, 16'h0, 3);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
